// File: rtl/caixa_pkg.sv
// Shared types and constants for the parametrised ATM PIN-entry controller.
package caixa_pkg;

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    LE_DIGITO      = 3'd1,
    VALIDA         = 3'd2,
    SAI_DINHEIRO   = 3'd3,
    DESTROI_CARTAO = 3'd4,
    ABORTA         = 3'd5
  } estado_t;

  // Widest packed PIN the digit extractor can handle.
  localparam int PIN_MAX_W = 64;

  localparam logic [7:0] SEG_TABLE [0:7] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h00, 8'h00
  };

  // Digit i of a packed PIN; digit 0 lives in the most significant slot.
  function automatic logic [31:0] pin_digit(input logic [PIN_MAX_W-1:0] pin,
                                            input int digit_w,
                                            input int pin_len,
                                            input int i);
    logic [PIN_MAX_W-1:0] sh;
    logic [PIN_MAX_W-1:0] mask;
    sh   = pin >> ((pin_len - 1 - i) * digit_w);
    mask = (PIN_MAX_W'(1) << digit_w) - PIN_MAX_W'(1);
    return 32'(sh & mask);
  endfunction

endpackage

// File: rtl/caixa_eletronico_param_detecta_borda.sv
// One-flop rising-edge detector: pulse is high for one cycle per 0->1 transition of in.
module detecta_borda (
  input  logic clk_2,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_d;

  always_ff @(posedge clk_2) begin
    if (reset) in_d <= 1'b0;
    else       in_d <= in;
  end

  assign pulse = in & ~in_d;

endmodule

// File: rtl/caixa_eletronico_param.sv
// Parametrised ATM PIN-entry controller with lockout after MAX_TRIES wrong PINs.
// Define ATM_TIMEOUT_EN to abort PIN entry after TIMEOUT_CYC idle cycles.
module caixa_eletronico_param
  import caixa_pkg::*;
#(
  parameter int DIGIT_W   = 3,
  parameter int PIN_LEN   = 3,
  parameter int MAX_TRIES = 4,
  parameter logic [PIN_LEN*DIGIT_W-1:0] PIN = {3'd1, 3'd3, 3'd7},
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                           clk_2,
  input  logic                           reset,
  input  logic                           cartao,
  input  logic                           entra,
  input  logic [DIGIT_W-1:0]             cod,
  output logic                           dinheiro,
  output logic                           destroi,
  output logic [2:0]                     estado_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] erros,
  output logic [$clog2(PIN_LEN+1)-1:0]   idx_o,
  output logic [7:0]                     seg_o
);

  localparam int ERR_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(PIN_LEN + 1);

  estado_t            estado_q;
  logic [ERR_W-1:0]   erros_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DIGIT_W-1:0] dig_q [PIN_LEN];
  logic               ent_pulse;
  logic               digit_ok;
  logic               pin_ok;
  logic               timeout_hit;

  detecta_borda u_borda_entra (
    .clk_2 (clk_2),
    .reset (reset),
    .in    (entra),
    .pulse (ent_pulse)
  );

  assign digit_ok = ent_pulse && (cod != '0);

  always_comb begin
    pin_ok = 1'b1;
    for (int i = 0; i < PIN_LEN; i++) begin
      if (dig_q[i] != DIGIT_W'(pin_digit(PIN_MAX_W'(PIN), DIGIT_W, PIN_LEN, i)))
        pin_ok = 1'b0;
    end
  end

`ifdef ATM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;

  // Counts idle cycles in LE_DIGITO; held at zero everywhere else so entry starts fresh.
  always_ff @(posedge clk_2) begin
    if (reset || estado_q != LE_DIGITO || digit_ok) tmr_q <= '0;
    else if (tmr_q != TMR_W'(TIMEOUT_CYC))          tmr_q <= tmr_q + 1'b1;
  end

  assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      estado_q <= INICIAL;
      erros_q  <= '0;
      idx_q    <= '0;
      for (int i = 0; i < PIN_LEN; i++) dig_q[i] <= '0;
    end else begin
      case (estado_q)
        INICIAL: begin
          idx_q <= '0;
          for (int i = 0; i < PIN_LEN; i++) dig_q[i] <= '0;
          if (cartao && cod == '0) estado_q <= LE_DIGITO;
        end
        LE_DIGITO: begin
          // Card removal wins over a simultaneous key press and the timeout.
          if (!cartao) begin
            estado_q <= ABORTA;
          end else if (digit_ok) begin
            for (int i = 0; i < PIN_LEN; i++)
              if (idx_q == IDX_W'(i)) dig_q[i] <= cod;
            if (idx_q == IDX_W'(PIN_LEN - 1)) estado_q <= VALIDA;
            else                              idx_q    <= idx_q + 1'b1;
          end else if (timeout_hit) begin
            estado_q <= ABORTA;
          end
        end
        VALIDA: begin
          if (pin_ok) begin
            estado_q <= SAI_DINHEIRO;
            erros_q  <= '0;
          end else begin
            if (erros_q != ERR_W'(MAX_TRIES)) erros_q <= erros_q + 1'b1;
            if (erros_q >= ERR_W'(MAX_TRIES - 1)) estado_q <= DESTROI_CARTAO;
            else                                  estado_q <= INICIAL;
          end
        end
        SAI_DINHEIRO: begin
          if (!cartao) estado_q <= INICIAL;
        end
        DESTROI_CARTAO: begin
          estado_q <= DESTROI_CARTAO;
        end
        ABORTA: begin
          idx_q <= '0;
          for (int i = 0; i < PIN_LEN; i++) dig_q[i] <= '0;
          estado_q <= INICIAL;
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  assign dinheiro = (estado_q == SAI_DINHEIRO);
  assign destroi  = (estado_q == DESTROI_CARTAO);
  assign estado_o = estado_q;
  assign erros    = erros_q;
  assign idx_o    = idx_q;
  assign seg_o    = SEG_TABLE[estado_q];

endmodule

// File: tb/tb_caixa_eletronico_param.sv
// Bench for caixa_eletronico_param: two instances (default and wide generics) against a digit-list model.
module tb_caixa_eletronico_param;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       cartao0, entra0;
  logic [2:0] cod0;
  logic       cartao1, entra1;
  logic [3:0] cod1;

  logic       dinheiro0, destroi0, dinheiro1, destroi1;
  logic [2:0] estado0, estado1;
  logic [2:0] erros0;
  logic [1:0] erros1;
  logic [1:0] idx0;
  logic [2:0] idx1;
  logic [7:0] seg0, seg1;

  int total = 0;
  int bad   = 0;

  always #5 clk_2 = ~clk_2;

  caixa_eletronico_param #(.TIMEOUT_CYC(20)) dut0 (
    .clk_2(clk_2), .reset(reset), .cartao(cartao0), .entra(entra0), .cod(cod0),
    .dinheiro(dinheiro0), .destroi(destroi0), .estado_o(estado0), .erros(erros0),
    .idx_o(idx0), .seg_o(seg0)
  );

  caixa_eletronico_param #(.DIGIT_W(4), .PIN_LEN(5), .MAX_TRIES(2), .PIN(20'h1F2A3)) dut1 (
    .clk_2(clk_2), .reset(reset), .cartao(cartao1), .entra(entra1), .cod(cod1),
    .dinheiro(dinheiro1), .destroi(destroi1), .estado_o(estado1), .erros(erros1),
    .idx_o(idx1), .seg_o(seg1)
  );

  // Reference model: state number, error count and the list of digits typed so far.
  int     m_w[2]   = '{3, 4};
  int     m_len[2] = '{3, 5};
  int     m_max[2] = '{4, 2};
  int     m_to[2]  = '{20, 1000};
  longint m_pin[2] = '{64'o137, 64'h1F2A3};
  int     seg_exp[8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h00, 8'h00};
  int     m_st[2], m_er[2], m_prev[2], m_cnt[2], m_t[2];
  int     m_dig[2][8];

  function automatic int pin_dig(int k, int i);
    return int'((m_pin[k] >> ((m_len[k] - 1 - i) * m_w[k])) & ((64'd1 << m_w[k]) - 1));
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic mstep(input int k, input bit c, input bit e, input int d);
    bit     pulse;
    longint v;
    pulse = e && !m_prev[k];
    if (reset) begin
      m_st[k] = 0; m_er[k] = 0; m_cnt[k] = 0; m_t[k] = 0; m_prev[k] = 0;
      return;
    end
    m_prev[k] = e;
    case (m_st[k])
      0: begin
        m_cnt[k] = 0;
        if (c && d == 0) begin m_st[k] = 1; m_t[k] = 0; end
      end
      1: begin
        if (!c) m_st[k] = 5;
        else if (pulse && d != 0) begin
          m_dig[k][m_cnt[k]] = d;
          m_cnt[k]++;
          m_t[k] = 0;
          if (m_cnt[k] == m_len[k]) m_st[k] = 2;
        end
`ifdef ATM_TIMEOUT_EN
        else begin
          m_t[k]++;
          if (m_t[k] == m_to[k]) m_st[k] = 5;
        end
`endif
      end
      2: begin
        v = 0;
        for (int i = 0; i < m_len[k]; i++) v = v * (64'd1 << m_w[k]) + m_dig[k][i];
        if (v == m_pin[k]) begin m_st[k] = 3; m_er[k] = 0; end
        else begin
          if (m_er[k] < m_max[k]) m_er[k]++;
          m_st[k] = (m_er[k] == m_max[k]) ? 4 : 0;
        end
      end
      3: if (!c) m_st[k] = 0;
      4: ;
      default: begin m_cnt[k] = 0; m_st[k] = 0; end
    endcase
  endtask

  task automatic check_all();
    int ix0, ix1;
    ix0 = (m_cnt[0] == m_len[0]) ? m_len[0] - 1 : m_cnt[0];
    ix1 = (m_cnt[1] == m_len[1]) ? m_len[1] - 1 : m_cnt[1];
    chk("estado0", estado0, m_st[0]);
    chk("erros0", erros0, m_er[0]);
    chk("idx0", idx0, ix0);
    chk("dinheiro0", dinheiro0, int'(m_st[0] == 3));
    chk("destroi0", destroi0, int'(m_st[0] == 4));
    chk("seg0", seg0, seg_exp[m_st[0]]);
    chk("estado1", estado1, m_st[1]);
    chk("erros1", erros1, m_er[1]);
    chk("idx1", idx1, ix1);
    chk("dinheiro1", dinheiro1, int'(m_st[1] == 3));
    chk("destroi1", destroi1, int'(m_st[1] == 4));
    chk("seg1", seg1, seg_exp[m_st[1]]);
  endtask

  // Inputs are set at the falling edge; the model steps on the rising edge and outputs are checked 1 ns later.
  task automatic tick();
    @(posedge clk_2);
    mstep(0, cartao0, entra0, int'(cod0));
    mstep(1, cartao1, entra1, int'(cod1));
    #1;
    check_all();
    @(negedge clk_2);
  endtask

  task automatic press(input int k, input int d);
    if (k == 0) begin cod0 = 3'(d); entra0 = 1'b1; end
    else        begin cod1 = 4'(d); entra1 = 1'b1; end
    tick();
    if (k == 0) entra0 = 1'b0; else entra1 = 1'b0;
    tick();
  endtask

  task automatic start(input int k);
    if (k == 0) begin cartao0 = 1'b1; cod0 = '0; end
    else        begin cartao1 = 1'b1; cod1 = '0; end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cartao0 = 0; entra0 = 0; cod0 = '0;
    cartao1 = 0; entra1 = 0; cod1 = '0;
    @(negedge clk_2);
    tick();
    tick();
    chk("reset_estado0", estado0, 0);
    chk("reset_seg0", seg0, 8'h3F);
    reset = 1'b0;

    // Correct PIN on the default instance.
    start(0);
    press(0, 1); press(0, 3); press(0, 7);
    chk("cash_after_pin", dinheiro0, 1);
    chk("cash_erros", erros0, 0);
    cartao0 = 1'b0;
    tick(); tick();
    chk("cash_dropped", dinheiro0, 0);

    // Four wrong PINs destroy the card.
    for (int a = 0; a < 4; a++) begin
      start(0);
      press(0, 2); press(0, 2); press(0, 2);
      if (a < 3) chk("lock_erros", erros0, a + 1);
    end
    chk("lock_destroi", destroi0, 1);
    chk("lock_estado", estado0, 4);
    for (int i = 0; i < 6; i++) begin
      cartao0 = 1'($urandom_range(0, 1)); entra0 = 1'($urandom_range(0, 1));
      cod0 = 3'($urandom_range(0, 7));
      tick();
    end
    chk("lock_absorb", destroi0, 1);
    cartao0 = 1'b0; entra0 = 1'b0;
    do_reset();
    chk("lock_reset_destroi", destroi0, 0);
    chk("lock_reset_erros", erros0, 0);

    // Held key enters one digit; a zero digit is ignored.
    start(0);
    cod0 = 3'd1; entra0 = 1'b1;
    repeat (10) tick();
    entra0 = 1'b0;
    tick();
    chk("held_key_idx", idx0, 1);
    press(0, 0);
    chk("zero_digit_idx", idx0, 1);

    // Card pulled on the same edge as a press.
    press(0, 4);
    cartao0 = 1'b0; entra0 = 1'b1; cod0 = 3'd5;
    tick();
    chk("abort_estado", estado0, 5);
    entra0 = 1'b0;
    tick();
    chk("abort_idx", idx0, 0);
    chk("abort_erros", erros0, 0);

    // Wide generics: 5 digits of 4 bits.
    start(1);
    press(1, 1); press(1, 15); press(1, 2); press(1, 10); press(1, 3);
    chk("wide_cash", dinheiro1, 1);
    cartao1 = 1'b0;
    tick(); tick();
    start(1);
    press(1, 1); press(1, 15); press(1, 2); press(1, 10); press(1, 4);
    chk("wide_erros", erros1, 1);

`ifdef ATM_TIMEOUT_EN
    do_reset();
    start(0);
    press(0, 1);
    repeat (18) tick();
    press(0, 3);
    chk("to_restart_idx", idx0, 2);
    repeat (25) tick();
    chk("to_estado", estado0, 0);
    chk("to_erros", erros0, 0);
`endif

    // Random traffic on both instances, biased toward the correct next digit.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset = ($urandom_range(0, 149) == 0);
      cartao0 = ($urandom_range(0, 19) != 0);
      cartao1 = ($urandom_range(0, 19) != 0);
      entra0 = 1'($urandom_range(0, 1));
      entra1 = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 2) cod0 = '0;
      else if (r < 6 && m_cnt[0] < m_len[0]) cod0 = 3'(pin_dig(0, m_cnt[0]));
      else cod0 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 2) cod1 = '0;
      else if (r < 6 && m_cnt[1] < m_len[1]) cod1 = 4'(pin_dig(1, m_cnt[1]));
      else cod1 = 4'($urandom_range(0, 15));
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/caixa_eletronico_param.md
Name: caixa_eletronico_param

Overview:
- Parametrised ATM PIN-entry controller; next generation of the fixed 3-digit, 3-bit ATM state machine on the board top.
- Adds generic PIN length, digit width, attempt limit and PIN value, plus edge-qualified digit entry and card-removal abort.
- Adds an optional inactivity timeout.
- Instantiated in top: inputs from SWI, outputs to LED and the seven-segment display (SEG).

Parameters:
- DIGIT_W, 3: bits per PIN digit; digit value 0 is reserved as "no digit".
- PIN_LEN, 3: number of digits per PIN, at least 1.
- MAX_TRIES, 4: consecutive wrong PINs that destroy the card, at least 1.
- PIN, {3'd1,3'd3,3'd7}: packed PIN_LEN*DIGIT_W constant; first digit in the MSBs; every digit must be nonzero.
- TIMEOUT_CYC, 1000: idle cycles in LE_DIGITO before abort (only with ATM_TIMEOUT_EN).

Ports:
- clk_2  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cartao  in  1  card present (level)
- entra  in  1  digit-enter key (level; sampled for rising edge)
- cod  in  DIGIT_W  digit value from switches
- dinheiro  out  1  cash dispensed
- destroi  out  1  card destroyed
- estado_o  out  3  current state encoding
- erros  out  $clog2(MAX_TRIES+1)  consecutive failed attempts
- idx_o  out  $clog2(PIN_LEN+1)  digits accepted in the current attempt
- seg_o  out  8  seven-segment pattern of estado_o

Behaviour:
- Reset is synchronous only: it is sampled at posedge clk_2 when reset=1.
- Reset values: estado=INICIAL, erros=0, idx=0, digit buffer=0, entra_d=0, timeout count=0, dinheiro=0, destroi=0.
- Reset mid-operation (any state, including DESTROI_CARTAO) returns to INICIAL on the next edge.
- Entry event: ent_pulse = entra & ~entra_d, where entra_d is entra registered.
  - Exactly one event per press; holding entra never enters more than one digit.
  - entra_d is updated in every state.
- States, encoded 0..5: INICIAL, LE_DIGITO, VALIDA, SAI_DINHEIRO, DESTROI_CARTAO, ABORTA.
- INICIAL:
  - Clears idx and the buffer.
  - Goes to LE_DIGITO when cartao=1 and cod=0.
- LE_DIGITO:
  - Card removal: cartao=0 goes to ABORTA. This has priority over a simultaneous ent_pulse. erros is unchanged.
  - ent_pulse with cod=0 is ignored.
  - ent_pulse with cod≠0 stores cod at slot idx.
    - If idx=PIN_LEN-1, go to VALIDA.
    - Otherwise idx=idx+1.
- VALIDA (exactly one cycle):
  - Buffer==PIN: go to SAI_DINHEIRO and clear erros to 0.
  - Otherwise erros=erros+1. Go to DESTROI_CARTAO if the new value equals MAX_TRIES, else to INICIAL.
  - erros saturates at MAX_TRIES and never wraps.
- SAI_DINHEIRO: stays until cartao=0, then goes to INICIAL.
- DESTROI_CARTAO: absorbing; only reset leaves it.
- ABORTA: one cycle, clears idx and the buffer, then goes to INICIAL.
- Outputs are Moore, decoded from the registered state:
  - dinheiro=1 iff SAI_DINHEIRO.
  - destroi=1 iff DESTROI_CARTAO.
- seg_o digit patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D; other encodings give 0x00.
- Latency: the card is destroyed 2 cycles after the last digit's ent_pulse edge (LE_DIGITO→VALIDA→DESTROI_CARTAO); cash is dispensed after the same 2 cycles.

Optional Feature:
- Macro: ATM_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYC+1) bits runs in LE_DIGITO and clears on every accepted digit and on state entry.
  - On reaching TIMEOUT_CYC, go to ABORTA; erros is not incremented.
  - cartao=0 has priority over the timeout.
- Undefined: no counter, no timeout path; LE_DIGITO waits indefinitely. The TIMEOUT_CYC parameter is ignored.

Decomposition:
- Package caixa_pkg:
  - estado_t enum (logic [2:0]) with the six states.
  - SEG_TABLE constant (array of 8-bit patterns indexed by state).
  - Function pin_digit(pin, i) extracting digit i from the packed PIN.
- Sub-module detecta_borda (clk_2, reset, in, pulse): one-flop rising-edge detector used for entra; natural and reusable for other keys.

Test Plan:
- Correct PIN (default params): reset; cartao=1, cod=0; enter 1, 3, 7 with one pulse each → VALIDA, then dinheiro=1 two cycles after the 7 pulse, erros=0; drop cartao → INICIAL, dinheiro=0.
- Lockout: four wrong PINs (2,2,2) → erros steps 1, 2, 3 with a return to INICIAL each time; the 4th attempt → destroi=1, estado_o=4; further cartao/entra activity has no effect; reset → INICIAL, destroi=0, erros=0.
- Edge qualification: hold entra=1 for 10 cycles with cod=1 → idx_o=1 only; a press with cod=0 → idx_o unchanged.
- Abort: after 2 digits set cartao=0 in the same cycle as an ent_pulse → ABORTA then INICIAL, idx_o=0, erros unchanged.
- Generics: PIN_LEN=5, DIGIT_W=4, PIN=0x1F2A3 (digits 1,15,2,10,3) entered correctly → dinheiro=1; the same digits with the last one =4 → erros=1.
- ATM_TIMEOUT_EN, TIMEOUT_CYC=20: enter one digit, then idle 20 cycles → ABORTA, then INICIAL, erros=0; a digit entered at cycle 19 restarts the count.
